// File: rtl/mips_pkg.sv
// Types and constants shared by the pipelined MIPS core.
// The instruction-fetch FSM states, the NOP bubble and the default reset PC live here.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF and drives the imem req/ack handshake.
// It absorbs memory latency, decode stalls and branch/jump redirects, and emits NOP bubbles.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic        FetchValidF,
  output logic [31:0] PCF
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  hold_instr_q;
  logic [31:0]  redir_pc_q;

  logic         redir;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  // Decode results are not final while stalled, so redirects only count when StallF is low.
  assign redir    = (PCSrcD | JumpD) & ~StallF;
  assign target   = (PCSrcD ? PCBranchD : PCJumpD) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;

  assign imem_addr = pc_q & 32'hFFFF_FFFC;
  assign PCF       = pc_q;
  assign PCPlus4F  = pc_plus4;

  always_comb begin
    imem_req    = 1'b0;
    FetchValidF = 1'b0;
    InstrF      = NOP_INSTR;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          // Data arriving with a redirect is wrong-path and gets squashed.
          if (imem_ack && !redir) begin
            FetchValidF = 1'b1;
            InstrF      = imem_rdata;
          end
        end
        HOLD: begin
          FetchValidF = 1'b1;
          InstrF      = hold_instr_q;
        end
        DRAIN: begin
          imem_req = 1'b1;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      redir_pc_q   <= 32'h0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            if (redir) begin
              pc_q <= target;
            end else if (StallF) begin
              hold_instr_q <= imem_rdata;
              state_q      <= HOLD;
            end else begin
              pc_q <= pc_plus4;
            end
          end else if (redir) begin
            // Request already in flight must complete at its address before the redirect.
            redir_pc_q <= target;
            state_q    <= DRAIN;
          end
        end
        HOLD: begin
          if (redir) begin
            pc_q    <= target;
            state_q <= FETCH;
          end else if (!StallF) begin
            pc_q    <= pc_plus4;
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc_q    <= redir ? target : redir_pc_q;
            state_q <= FETCH;
          end else if (redir) begin
            redir_pc_q <= target;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule
